sub_share_arbiter: RTL and testbench

- Shares one 32-bit subtract datapath (A − B, two's-complement, carry-in 1) among N_REQ requesters.
- Round-robin arbitration with a per-requester valid/ready request channel and a single valid/ready response channel tagged with the requester ID.
- Sits between the control units that need differences (address offsets, compare/branch, counters) and the shared subtractor.
- The subtractor itself stays purely combinational; all sequencing lives here.

---
 rtl/sub_share_pkg.sv | 22 ++
 rtl/sub_share_arbiter_rr_arbiter.sv | 31 +++
 rtl/sub_share_arbiter.sv | 144 ++++++++++++++
 tb/tb_sub_share_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_share_pkg.sv
// Shared types and constants for the shared-subtractor arbiter.
// Also provides a clog2 helper used to size requester IDs.
package sub_share_pkg;

  localparam int unsigned Width = 32;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/sub_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
// Reusable by any shared unit that needs a fair single grant.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any_grant
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      idx = ID_W'((32'(ptr) + off) % N_REQ);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Round-robin front end for one shared 32-bit subtractor (A - B).
// Accept in IDLE, subtract in EXEC, hold the tagged result in RESP.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = Width,
  parameter int unsigned ID_W  = clog2_f(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [WIDTH-1:0]       rsp_diff,
  output logic                   rsp_borrow,
  output logic                   rsp_zero,
  output logic                   rsp_ovf
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]  rsp_diff_q, rsp_diff_d;
  logic              rsp_borrow_q, rsp_borrow_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_ovf_q, rsp_ovf_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_grant;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Shared subtractor: A + ~B + 1; carry-out clear means A < B unsigned.
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_cout;

  assign sub_full = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
  assign sub_diff = sub_full[WIDTH-1:0];
  assign sub_cout = sub_full[WIDTH];

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_diff_d   = rsp_diff_q;
    rsp_borrow_d = rsp_borrow_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    req_ready    = '0;

    case (state_q)
      StIdle: begin
        req_ready = grant;
        // grant is a subset of req_valid, so any_grant is the handshake
        if (any_grant) begin
          for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              a_d = req_a[i*WIDTH +: WIDTH];
              b_d = req_b[i*WIDTH +: WIDTH];
            end
          end
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d  = StExec;
        end
      end
      StExec: begin
        rsp_diff_d   = sub_diff;
        rsp_borrow_d = ~sub_cout;
        rsp_zero_d   = (sub_diff == '0);
        rsp_ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_diff[WIDTH-1] != a_q[WIDTH-1]);
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_diff_q   <= '0;
      rsp_borrow_q <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_diff_q   <= rsp_diff_d;
      rsp_borrow_q <= rsp_borrow_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_diff   = rsp_diff_q;
  assign rsp_borrow = rsp_borrow_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_ovf    = rsp_ovf_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed bench for sub_share_arbiter: grant order, arithmetic flags, backpressure, reset.
module tb_sub_share_arbiter;

  localparam int unsigned NReq = 4;
  localparam int unsigned W    = 32;

  logic              clk;
  logic              rst_n;
  logic [NReq-1:0]   req_valid;
  logic [NReq-1:0]   req_ready;
  logic [NReq*W-1:0] req_a;
  logic [NReq*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [W-1:0]      rsp_diff;
  logic              rsp_borrow;
  logic              rsp_zero;
  logic              rsp_ovf;

  int tests;
  int fails;

  sub_share_arbiter #(
    .N_REQ (NReq),
    .WIDTH (W),
    .ID_W  (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow),
    .rsp_zero   (rsp_zero),
    .rsp_ovf    (rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
    tests++; if (rsp_id !== 2'd0) begin fails++; $display("FAIL reset_id got %0d want 0", rsp_id); end
    tests++; if (rsp_diff !== 32'd0) begin fails++; $display("FAIL reset_diff got %h want 0", rsp_diff); end
    tests++; if ({rsp_borrow, rsp_zero, rsp_ovf} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b want 000", {rsp_borrow, rsp_zero, rsp_ovf});
    end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL reset_ready got %b want 0000", req_ready); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100;
    req_a[2*W +: W] = 32'd10;
    req_b[2*W +: W] = 32'd3;
    #1;
    tests++; if (req_ready !== 4'b0100) begin fails++; $display("FAIL single_ready got %b want 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_t1_valid got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL single_exec_ready got %b want 0000", req_ready); end
    step();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL single_t2_valid got %b want 1", rsp_valid); end
    tests++; if (rsp_id !== 2'd2) begin fails++; $display("FAIL single_id got %0d want 2", rsp_id); end
    tests++; if (rsp_diff !== 32'd7) begin fails++; $display("FAIL single_diff got %h want 7", rsp_diff); end
    tests++; if ({rsp_borrow, rsp_zero, rsp_ovf} !== 3'b000) begin
      fails++; $display("FAIL single_flags got %b want 000", {rsp_borrow, rsp_zero, rsp_ovf});
    end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [1:0] g;
    apply_reset();
    for (int i = 0; i < NReq; i++) begin
      req_a[i*W +: W] = 32'(1000 * (i + 1));
      req_b[i*W +: W] = 32'(i);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      g = 2'(k % 4);
      tests++; if (req_ready !== (4'b0001 << g)) begin
        fails++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'b0001 << g);
      end
      step();
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_id !== g) begin
        fails++; $display("FAIL rr_rsp%0d got v=%b id=%0d want v=1 id=%0d", k, rsp_valid, rsp_id, g);
      end
      tests++; if (rsp_diff !== 32'(1000 * (g + 1) - g)) begin
        fails++; $display("FAIL rr_diff%0d got %0d want %0d", k, rsp_diff, 1000 * (g + 1) - g);
      end
      step();
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_boundaries();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vd [4];
    logic [2:0]   vf [4];
    va[0] = 32'h0000_0000; vb[0] = 32'h0000_0001; vd[0] = 32'hFFFF_FFFF; vf[0] = 3'b100;
    va[1] = 32'h0000_0005; vb[1] = 32'h0000_0005; vd[1] = 32'h0000_0000; vf[1] = 3'b010;
    va[2] = 32'h8000_0000; vb[2] = 32'h0000_0001; vd[2] = 32'h7FFF_FFFF; vf[2] = 3'b001;
    va[3] = 32'h7FFF_FFFF; vb[3] = 32'hFFFF_FFFF; vd[3] = 32'h8000_0000; vf[3] = 3'b101;
    for (int k = 0; k < 4; k++) begin
      req_a[0 +: W] = va[k];
      req_b[0 +: W] = vb[k];
      req_valid = 4'b0001;
      #1;
      tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL bnd_ready%0d got %b want 0001", k, req_ready); end
      step();
      req_valid = '0;
      step();
      tests++; if (rsp_valid !== 1'b1 || rsp_diff !== vd[k]) begin
        fails++; $display("FAIL bnd_diff%0d got v=%b %h want v=1 %h", k, rsp_valid, rsp_diff, vd[k]);
      end
      tests++; if ({rsp_borrow, rsp_zero, rsp_ovf} !== vf[k]) begin
        fails++; $display("FAIL bnd_flags%0d got %b want %b", k, {rsp_borrow, rsp_zero, rsp_ovf}, vf[k]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req_a[0 +: W] = 32'd100;
    req_b[0 +: W] = 32'd40;
    req_a[W +: W] = 32'd9;
    req_b[W +: W] = 32'd4;
    req_valid = 4'b0001;
    #1;
    step();
    req_valid = 4'b0010;
    step();
    for (int k = 0; k < 5; k++) begin
      tests++; if (rsp_valid !== 1'b1 || rsp_diff !== 32'd60 || rsp_id !== 2'd0) begin
        fails++; $display("FAIL bp_hold%0d got v=%b d=%0d id=%0d want v=1 d=60 id=0", k, rsp_valid, rsp_diff, rsp_id);
      end
      tests++; if (req_ready !== 4'b0000) begin fails++; $display("FAIL bp_ready%0d got %b want 0000", k, req_ready); end
      if (k < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release got %b want 0", rsp_valid); end
    tests++; if (req_ready !== 4'b0010) begin fails++; $display("FAIL bp_next_grant got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    step();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_diff !== 32'd5) begin
      fails++; $display("FAIL bp_second got v=%b id=%0d d=%0d want v=1 id=1 d=5", rsp_valid, rsp_id, rsp_diff);
    end
    step();
  endtask

  task automatic test_reset_exec();
    int seen;
    seen = 0;
    req_a[0 +: W] = 32'd50;
    req_b[0 +: W] = 32'd8;
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rx_accept got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid !== 1'b0) seen++;
      step();
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid !== 1'b0) seen++;
      step();
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL rx_no_rsp got %0d valid cycles want 0", seen); end
    req_a[3*W +: W] = 32'd77;
    req_b[3*W +: W] = 32'd7;
    req_valid = 4'b1001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL rx_ptr_reset got %b want 0001", req_ready); end
    step();
    req_valid = 4'b1000;
    step();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_diff !== 32'd42) begin
      fails++; $display("FAIL rx_after got v=%b id=%0d d=%0d want v=1 id=0 d=42", rsp_valid, rsp_id, rsp_diff);
    end
    step();
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL rx_next got %b want 1000", req_ready); end
    step();
    req_valid = '0;
    step();
    tests++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_diff !== 32'd70) begin
      fails++; $display("FAIL rx_req3 got v=%b id=%0d d=%0d want v=1 id=3 d=70", rsp_valid, rsp_id, rsp_diff);
    end
    step();
  endtask

  task automatic test_ptr_wrap();
    req_a[0 +: W] = 32'd3;
    req_b[0 +: W] = 32'd5;
    req_valid = 4'b1001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL wrap_grant got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    step();
    tests++; if (rsp_id !== 2'd0 || rsp_diff !== 32'hFFFF_FFFE || rsp_borrow !== 1'b1) begin
      fails++; $display("FAIL wrap_rsp got id=%0d d=%h b=%b want id=0 d=fffffffe b=1", rsp_id, rsp_diff, rsp_borrow);
    end
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_boundaries();
    test_backpressure();
    test_reset_exec();
    test_ptr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
